// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state encoding and default sizes for the bus arbiter
package bus_arb_pkg;

  // Arbiter FSM states; TURN is the dead cycle between two owners
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arbState_t;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_MAX_HOLD  = 255;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin winner selection
module rr_select #(
  parameter int NUM_CORES = 4,
  parameter int OWNER_W   = 2
) (
  input  logic [NUM_CORES-1:0] reqVec,
  input  logic [OWNER_W-1:0]   ptr,
  output logic [OWNER_W-1:0]   winner,
  output logic                 valid
);

  logic [2*NUM_CORES-1:0] doubled;
  logic [NUM_CORES-1:0]   rotated;
  logic [OWNER_W-1:0]     rotIdx;
  logic [OWNER_W:0]       sum;

  // Rotate so the pointer slot sits at bit 0, pick lowest set bit, rotate the index back
  always_comb begin
    doubled = {reqVec, reqVec} >> ptr;
    rotated = doubled[NUM_CORES-1:0];
    valid   = |rotated;
    rotIdx  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rotated[i]) rotIdx = OWNER_W'(i);
    end
    sum = {1'b0, rotIdx} + {1'b0, ptr};
    if (sum >= (OWNER_W+1)'(NUM_CORES)) sum = sum - (OWNER_W+1)'(NUM_CORES);
    winner = sum[OWNER_W-1:0];
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with turnaround cycle and hold timeout
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int OWNER_W   = $clog2(NUM_CORES),
  parameter int MAX_HOLD  = DEF_MAX_HOLD,
  parameter int HOLD_W    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] Bus_RQ,
  output logic [NUM_CORES-1:0] Bus_GRANT,
  output logic [OWNER_W-1:0]   Bus_Owner,
  output logic                 Bus_Busy,
  output logic                 Hold_Timeout,
  output logic [OWNER_W-1:0]   Timeout_Owner
);

  arbState_t              state;
  arbState_t              stateNext;
  logic [OWNER_W-1:0]     rrPtr;
  logic [OWNER_W-1:0]     rrPtrNext;
  logic [OWNER_W-1:0]     ownerNext;
  logic [OWNER_W-1:0]     winner;
  logic                   winValid;
  logic [NUM_CORES-1:0]   grantNext;
  logic [HOLD_W-1:0]      holdCnt;
  logic [HOLD_W-1:0]      holdNext;
  logic [HOLD_W-1:0]      holdInc;
  logic                   timeoutNext;
  logic [OWNER_W-1:0]     toOwnerNext;

  rr_select #(
    .NUM_CORES (NUM_CORES),
    .OWNER_W   (OWNER_W)
  ) uRrSelect (
    .reqVec (Bus_RQ),
    .ptr    (rrPtr),
    .winner (winner),
    .valid  (winValid)
  );

  assign Bus_Busy = (state == ST_GRANT);

  // Next-state, next-grant and hold-counter decisions for the arbitration FSM
  always_comb begin
    stateNext   = state;
    grantNext   = '0;
    ownerNext   = Bus_Owner;
    rrPtrNext   = rrPtr;
    holdNext    = holdCnt;
    timeoutNext = Hold_Timeout;
    toOwnerNext = Timeout_Owner;
    holdInc     = (holdCnt == {HOLD_W{1'b1}}) ? holdCnt : holdCnt + HOLD_W'(1);
    case (state)
      ST_IDLE, ST_TURN: begin
        if (winValid) begin
          stateNext = ST_GRANT;
          grantNext = NUM_CORES'(1) << winner;
          ownerNext = winner;
          rrPtrNext = (winner == OWNER_W'(NUM_CORES - 1)) ? '0 : winner + OWNER_W'(1);
          holdNext  = '0;
        end else begin
          stateNext = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Every GRANT cycle counts toward the hold limit, including the releasing one
        holdNext = holdInc;
        if (!Hold_Timeout && (holdInc == HOLD_W'(MAX_HOLD))) begin
          timeoutNext = 1'b1;
          toOwnerNext = Bus_Owner;
        end
        if (Bus_RQ[Bus_Owner]) begin
          grantNext = Bus_GRANT;
        end else begin
          stateNext = ST_TURN;
        end
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      Bus_GRANT     <= '0;
      Bus_Owner     <= '0;
      rrPtr         <= '0;
      holdCnt       <= '0;
      Hold_Timeout  <= 1'b0;
      Timeout_Owner <= '0;
    end else begin
      state         <= stateNext;
      Bus_GRANT     <= grantNext;
      Bus_Owner     <= ownerNext;
      rrPtr         <= rrPtrNext;
      holdCnt       <= holdNext;
      Hold_Timeout  <= timeoutNext;
      Timeout_Owner <= toOwnerNext;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed bench for bus_arbiter against a reference model
module tb_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] Bus_RQ;
  logic [N-1:0] Bus_GRANT;
  logic [1:0]   Bus_Owner;
  logic         Bus_Busy;
  logic         Hold_Timeout;
  logic [1:0]   Timeout_Owner;

  int nChecks = 0;
  int nPass   = 0;

  // reference model: who holds the bus and the bookkeeping the rules imply
  bit   mGranted;
  int   mOwner;
  int   mPtr;
  int   mHold;
  bit   mTo;
  int   mToOwner;
  logic [N-1:0] prevGrant;

  bus_arbiter #(
    .NUM_CORES (N),
    .OWNER_W   (2),
    .MAX_HOLD  (MAXH),
    .HOLD_W    (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .Bus_RQ        (Bus_RQ),
    .Bus_GRANT     (Bus_GRANT),
    .Bus_Owner     (Bus_Owner),
    .Bus_Busy      (Bus_Busy),
    .Hold_Timeout  (Hold_Timeout),
    .Timeout_Owner (Timeout_Owner)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic modelReset();
    mGranted = 0;
    mOwner   = 0;
    mPtr     = 0;
    mHold    = 0;
    mTo      = 0;
    mToOwner = 0;
    prevGrant = '0;
  endtask

  // one rising edge of the arbiter as described by its rules
  task automatic modelEdge(input logic [N-1:0] rq);
    bit found;
    int idx;
    if (mGranted) begin
      mHold = mHold + 1;
      if (!mTo && mHold == MAXH) begin
        mTo      = 1;
        mToOwner = mOwner;
      end
      if (!rq[mOwner]) mGranted = 0;
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (mPtr + k) % N;
        if (!found && rq[idx]) begin
          found    = 1;
          mGranted = 1;
          mOwner   = idx;
          mPtr     = (idx + 1) % N;
          mHold    = 0;
        end
      end
    end
  endtask

  task automatic checkAll(input logic [N-1:0] rq);
    logic [N-1:0] expGrant;
    expGrant = mGranted ? (N'(1) << mOwner) : '0;
    checkVal("grant", Bus_GRANT, expGrant);
    checkVal("owner", Bus_Owner, mOwner);
    checkVal("busy", Bus_Busy, mGranted);
    checkVal("timeout", Hold_Timeout, mTo);
    checkVal("timeout_owner", Timeout_Owner, mToOwner);
    checkVal("onehot", $onehot0(Bus_GRANT), 1);
    if (Bus_GRANT != '0 && Bus_GRANT != prevGrant)
      checkVal("grant_had_rq", |(Bus_GRANT & ~rq), 0);
    prevGrant = Bus_GRANT;
  endtask

  task automatic edgeCheck(input logic [N-1:0] rq);
    @(posedge clock);
    modelEdge(rq);
    #1;
    checkAll(rq);
  endtask

  task automatic step(input logic [N-1:0] rq);
    @(negedge clock);
    Bus_RQ = rq;
    edgeCheck(rq);
  endtask

  // called 1 time unit after a rising edge; asserts reset mid-cycle
  task automatic midReset(input logic [N-1:0] relRq);
    #3;
    reset = 1'b1;
    #1;
    checkVal("rst_grant", Bus_GRANT, 0);
    checkVal("rst_timeout", Hold_Timeout, 0);
    checkVal("rst_busy", Bus_Busy, 0);
    modelReset();
    @(negedge clock);
    Bus_RQ = relRq;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    edgeCheck(relRq);
  endtask

  logic [N-1:0] rqv;
  logic [N-1:0] mask;

  initial begin
    reset  = 1'b1;
    Bus_RQ = '0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkAll('0);
    @(negedge clock);
    reset = 1'b0;

    // single requester
    repeat (4) step('0);
    step(4'b0100);
    checkVal("single_grant", Bus_GRANT, 4'b0100);
    checkVal("single_owner", Bus_Owner, 2);
    repeat (5) step(4'b0100);
    step('0);
    checkVal("single_drop", Bus_GRANT, 0);
    step('0);
    checkVal("single_idle_owner", Bus_Owner, 2);

    // round-robin fairness from a fresh pointer
    midReset('0);
    for (int g = 0; g < 5; g++) begin
      step(4'b1111);
      checkVal("rr_order", Bus_GRANT, 4'b0001 << (g % 4));
      step(4'b1111);
      step(4'b1111);
      mask = 4'b1111 & ~(4'b0001 << (g % 4));
      step(mask);
      checkVal("rr_turn", Bus_GRANT, 0);
    end

    // handover race: core 1 drops as core 3 raises
    step(4'b0010);
    checkVal("race_own1", Bus_GRANT, 4'b0010);
    step(4'b0010);
    step(4'b1000);
    checkVal("race_turn", Bus_GRANT, 0);
    step(4'b1000);
    checkVal("race_new", Bus_GRANT, 4'b1000);
    step('0);
    step('0);

    // long hold raises the sticky timeout without revoking the grant
    for (int i = 1; i <= 20; i++) begin
      step(4'b0100);
      if (i == 8) checkVal("to_early", Hold_Timeout, 0);
      if (i == 9) begin
        checkVal("to_set", Hold_Timeout, 1);
        checkVal("to_owner", Timeout_Owner, 2);
      end
    end
    checkVal("to_kept_grant", Bus_GRANT, 4'b0100);
    step('0);
    step('0);
    checkVal("to_sticky", Hold_Timeout, 1);

    // asynchronous reset while core 0 owns the bus
    repeat (3) step(4'b0001);
    checkVal("pre_rst_grant", Bus_GRANT, 4'b0001);
    midReset(4'b0011);
    checkVal("rst_first", Bus_GRANT, 4'b0001);

    // random traffic with sticky requests so holds get long
    rqv = 4'b0011;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) rqv = rqv ^ N'($urandom_range(0, 15));
      step(rqv);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
